bp_fe_lce_resp_arb: RTL and testbench
=====================================

# bp_fe_lce_resp_arb

Shares the FE LCE's single outbound LCE-to-CCE response channel between two producers: the miss-request FSM, which sends tr_ack/coh_ack, and the LCE command handler, which sends sync_ack/inv_ack/wb responses. The block holds the granted message in one output register, then presents it to the network with a valid/yumi handshake. It uses round-robin arbitration, with a strict-priority override for the command path during CCE sync. It sits between those two FSMs and the lce_resp network port of the icache.

## Interface

**Parameters**
- num_cce_p, "inv": number of CCEs.
- num_lce_p, "inv": number of LCEs.
- lce_addr_width_p, "inv": physical address width.
- resp width (localparam) = `bp_lce_cce_resp_width(num_cce_p, num_lce_p, lce_addr_width_p)`.

**Ports**
- clk_i, input, 1: clock. One clock.
- reset_i, input, 1: synchronous, active-high reset.
- sync_mode_i, input, 1: the command handler is in the CCE sync phase.
- cmd_resp_i, input, resp width: response message from the command handler.
- cmd_resp_v_i, input, 1: cmd_resp_i is valid.
- cmd_resp_yumi_o, output, 1: cmd message consumed this cycle.
- req_resp_i, input, resp width: response message from the miss-request FSM.
- req_resp_v_i, input, 1: req_resp_i is valid.
- req_resp_yumi_o, output, 1: req message consumed this cycle.
- lce_resp_o, output, resp width: registered message to the network.
- lce_resp_v_o, output, 1: the output register holds a message.
- lce_resp_yumi_i, input, 1: the network consumes lce_resp_o this cycle.
- last_grant_o, output, 1: source of the message in the output register (0 = cmd, 1 = req).

## Operation

**States** (`bp_fe_lce_resp_arb_state_e`)
- e_resp_arb_empty: the output register is empty.
- e_resp_arb_full: the output register is occupied.

**Free slot**
- A slot is free when state is empty, or when state is full and lce_resp_yumi_i=1.

**Grant rules** (only when a slot is free)
- sync_mode_i=1: cmd has strict priority. Grant cmd if cmd_resp_v_i; otherwise grant req if req_resp_v_i.
- sync_mode_i=0: round-robin. Grant the valid source that is not the last-granted source. If only one source is valid, grant it.
- The round-robin pointer updates only on a grant, including grants made under sync override.

**Grant actions**
- Assert the winner's yumi_o in the same cycle.
- Load the winner's payload into the output register.
- Load last_grant_r with the winner.
- Next state is full.

**Slot free, no valid input**
- If full and lce_resp_yumi_i=1, go to empty.
- If already empty, stay empty.

**Full, lce_resp_yumi_i=0**
- Hold lce_resp_o, lce_resp_v_o and last_grant_o stable.
- Both yumi_o outputs stay 0.

**Protocol rules**
- yumi_o is never asserted without the matching v_i. At most one yumi_o is high per cycle.
- Upstream sources must hold v_i and payload until they see their yumi.

**Reset**
- state = empty.
- lce_resp_v_o = 0.
- Both yumi_o = 0.
- lce_resp_o = '0.
- last_grant_o = 1, so cmd wins the first contested round-robin grant.
- Reset asserted mid-transfer discards the buffered message. No yumi is issued in a reset cycle.

## Timing

- Input to output latency is 1 cycle: a grant at cycle t gives lce_resp_v_o=1 at t+1.
- Throughput is 1 message per cycle when lce_resp_yumi_i is continuously 1, because refill happens in the same cycle as drain.
- Combinational paths:
  - lce_resp_yumi_i to both yumi_o outputs.
  - v_i and sync_mode_i to both yumi_o outputs.
- There is no combinational path from any input to lce_resp_o or lce_resp_v_o.
- Simultaneous drain and refill leaves state full, and the new payload appears at t+1.
- sync_mode_i is sampled only in cycles with a free slot. Toggling it while full has no effect on the held message.

## Structure

- bp_fe_icache_pkg holds:
  - `bp_fe_lce_resp_arb_state_e`.
  - Source encoding constants e_resp_src_cmd=0 and e_resp_src_req=1.
- The message struct comes from `declare_bp_lce_cce_resp_s` in bp_common_pkg.
- One sub-module is natural: a 2-input round-robin arbiter, `bp_fe_rr_arb2`.
  - Inputs: reqs, sync priority override, grant-enable.
  - Outputs: one-hot grant.
  - Holds the pointer register internally.
- The output register and the FSM live in the top module.

## Test plan

1. **Reset and idle.** Hold reset 3 cycles, then drive no valids for 10 cycles. Require lce_resp_v_o=0, both yumi=0 and lce_resp_o=0 throughout.
2. **Single request.** Drive req_resp_v_i=1 with msg_type=tr_ack and addr=0x1040 at cycle t. Require req_resp_yumi_o=1 at t. Require lce_resp_v_o=1 at t+1 with addr 0x1040 and last_grant_o=1.
3. **Contention with round-robin.** Hold both valids with lce_resp_yumi_i=1 for 4 cycles. Require the grant order cmd, req, cmd, req (one message per cycle) and lce_resp_v_o continuously high from the second cycle.
4. **Sync override.** Set sync_mode_i=1 and hold both valids for 3 grants. Require cmd, cmd, cmd. Then clear sync_mode_i; require the next grant to be req.
5. **Backpressure.** Keep lce_resp_yumi_i=0 for 5 cycles while full and both sources are valid. Require lce_resp_o stable and both yumi=0. Raising lce_resp_yumi_i must refill in the same cycle.
6. **Reset mid-transfer.** Assert reset while full and stalled. Require lce_resp_v_o=0 on the next cycle. Require that the first contested grant after reset goes to cmd.

Source files
------------

// File: rtl/bp_fe_icache_pkg.sv
// Shared types for the FE icache LCE blocks: response arbiter state,
// source encoding and the LCE-to-CCE response message layout.
package bp_fe_icache_pkg;

   typedef enum logic {
      e_resp_arb_empty = 1'b0,
      e_resp_arb_full  = 1'b1
   } bp_fe_lce_resp_arb_state_e;

   // Source encoding, also the round-robin pointer value
   localparam logic e_resp_src_cmd = 1'b0;
   localparam logic e_resp_src_req = 1'b1;

   localparam int lce_cce_resp_type_width_gp = 3;

   typedef enum logic [lce_cce_resp_type_width_gp-1:0] {
      e_lce_cce_sync_ack     = 3'd0,
      e_lce_cce_inv_ack      = 3'd1,
      e_lce_cce_coh_ack      = 3'd2,
      e_lce_cce_tr_ack       = 3'd3,
      e_lce_cce_resp_wb      = 3'd4,
      e_lce_cce_resp_null_wb = 3'd5
   } bp_lce_cce_resp_type_e;

   // Id fields never collapse to zero bits, even with a single agent
   function automatic int bp_id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Message layout, MSB to LSB: {dst_cce_id, src_lce_id, msg_type, addr}
   function automatic int bp_lce_cce_resp_width(input int num_cce, input int num_lce,
                                                input int addr_w);
      return bp_id_width(num_cce) + bp_id_width(num_lce)
           + lce_cce_resp_type_width_gp + addr_w;
   endfunction

endpackage

// File: rtl/bp_fe_rr_arb2.sv
// Two-input round-robin arbiter with a strict-priority override for input 0.
// The pointer holds the last granted source and advances only on a grant.
module bp_fe_rr_arb2
   import bp_fe_icache_pkg::*;
(
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic [1:0] reqs_i,
   input  logic       sync_i,
   input  logic       en_i,
   output logic [1:0] grant_o,
   output logic       last_o
);

   logic last_q, last_d;

   // One-hot grant: input 0 wins outright under override, else alternate on contention
   always_comb begin
      grant_o = 2'b00;
      if (en_i) begin
         if (sync_i) begin
            grant_o[0] = reqs_i[0];
            grant_o[1] = reqs_i[1] & ~reqs_i[0];
         end else if (&reqs_i) begin
            grant_o[0] = (last_q == e_resp_src_req);
            grant_o[1] = (last_q == e_resp_src_cmd);
         end else begin
            grant_o = reqs_i;
         end
      end
   end

   // Pointer follows the winner; override grants count too
   always_comb begin
      last_d = last_q;
      if (grant_o[1])      last_d = e_resp_src_req;
      else if (grant_o[0]) last_d = e_resp_src_cmd;
   end

   // Pointer register; reset points at req so cmd wins the first contest
   always_ff @(posedge clk_i) begin
      if (reset_i) last_q <= e_resp_src_req;
      else         last_q <= last_d;
   end

   assign last_o = last_q;

endmodule

// File: rtl/bp_fe_lce_resp_arb.sv
// Shares the single outbound LCE response channel between the command
// handler and the miss-request FSM. The winner is captured in one output
// register and drained with valid/yumi; drain and refill may share a cycle.
module bp_fe_lce_resp_arb
   import bp_fe_icache_pkg::*;
#(
   parameter int num_cce_p        = 1,
   parameter int num_lce_p        = 2,
   parameter int lce_addr_width_p = 22,
   localparam int resp_width_lp   = bp_lce_cce_resp_width(num_cce_p, num_lce_p,
                                                          lce_addr_width_p)
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     sync_mode_i,
   input  logic [resp_width_lp-1:0] cmd_resp_i,
   input  logic                     cmd_resp_v_i,
   output logic                     cmd_resp_yumi_o,
   input  logic [resp_width_lp-1:0] req_resp_i,
   input  logic                     req_resp_v_i,
   output logic                     req_resp_yumi_o,
   output logic [resp_width_lp-1:0] lce_resp_o,
   output logic                     lce_resp_v_o,
   input  logic                     lce_resp_yumi_i,
   output logic                     last_grant_o
);

   bp_fe_lce_resp_arb_state_e state_q, state_d;
   logic [resp_width_lp-1:0]  data_q, data_d;
   logic                      slot_free;
   logic [1:0]                grant;

   // Slot is free when empty or being drained this cycle; never grant in reset
   always_comb begin
      slot_free = (state_q == e_resp_arb_empty) | lce_resp_yumi_i;
   end

   bp_fe_rr_arb2 u_arb (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .reqs_i  ({req_resp_v_i, cmd_resp_v_i}),
      .sync_i  (sync_mode_i),
      .en_i    (slot_free & ~reset_i),
      .grant_o (grant),
      .last_o  (last_grant_o)
   );

   assign cmd_resp_yumi_o = grant[0];
   assign req_resp_yumi_o = grant[1];

   // Next state and payload: refill on grant, go empty on bare drain, else hold
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      if (grant[0]) begin
         state_d = e_resp_arb_full;
         data_d  = cmd_resp_i;
      end else if (grant[1]) begin
         state_d = e_resp_arb_full;
         data_d  = req_resp_i;
      end else if ((state_q == e_resp_arb_full) && lce_resp_yumi_i) begin
         state_d = e_resp_arb_empty;
      end
   end

   // Output register and state; reset discards any buffered message
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= e_resp_arb_empty;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
      end
   end

   assign lce_resp_o   = data_q;
   assign lce_resp_v_o = (state_q == e_resp_arb_full);

endmodule

// File: tb/tb_bp_fe_lce_resp_arb.sv
// Directed bench for bp_fe_lce_resp_arb: reset/idle, single request,
// round-robin contention, sync override, backpressure and mid-transfer reset.
module tb_bp_fe_lce_resp_arb;
   import bp_fe_icache_pkg::*;

   localparam int NCCE = 1;
   localparam int NLCE = 2;
   localparam int AW   = 22;
   localparam int CW   = bp_id_width(NCCE);
   localparam int LW   = bp_id_width(NLCE);
   localparam int W    = bp_lce_cce_resp_width(NCCE, NLCE, AW);

   logic         clk = 1'b0;
   logic         reset_i;
   logic         sync_mode_i;
   logic [W-1:0] cmd_resp_i;
   logic         cmd_resp_v_i;
   logic         cmd_resp_yumi_o;
   logic [W-1:0] req_resp_i;
   logic         req_resp_v_i;
   logic         req_resp_yumi_o;
   logic [W-1:0] lce_resp_o;
   logic         lce_resp_v_o;
   logic         lce_resp_yumi_i;
   logic         last_grant_o;

   int n_cmp = 0;
   int n_err = 0;
   int cmd_cnt = 0;
   int req_cnt = 0;
   logic [W-1:0] held;

   always #5 clk = ~clk;

   bp_fe_lce_resp_arb #(
      .num_cce_p        (NCCE),
      .num_lce_p        (NLCE),
      .lce_addr_width_p (AW)
   ) dut (
      .clk_i           (clk),
      .reset_i         (reset_i),
      .sync_mode_i     (sync_mode_i),
      .cmd_resp_i      (cmd_resp_i),
      .cmd_resp_v_i    (cmd_resp_v_i),
      .cmd_resp_yumi_o (cmd_resp_yumi_o),
      .req_resp_i      (req_resp_i),
      .req_resp_v_i    (req_resp_v_i),
      .req_resp_yumi_o (req_resp_yumi_o),
      .lce_resp_o      (lce_resp_o),
      .lce_resp_v_o    (lce_resp_v_o),
      .lce_resp_yumi_i (lce_resp_yumi_i),
      .last_grant_o    (last_grant_o)
   );

   function automatic logic [W-1:0] mk(input logic [2:0] t, input logic [AW-1:0] a,
                                       input logic [LW-1:0] src);
      return {{CW{1'b0}}, src, t, a};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One cycle with both sources valid and the sink draining; checks the
   // combinational grant, then the registered result one cycle later.
   task automatic contest(input string tag, input logic exp_src);
      cmd_resp_i      = mk(e_lce_cce_inv_ack, AW'(22'h100 + cmd_cnt), 1'b0);
      req_resp_i      = mk(e_lce_cce_coh_ack, AW'(22'h200 + req_cnt), 1'b1);
      cmd_resp_v_i    = 1'b1;
      req_resp_v_i    = 1'b1;
      lce_resp_yumi_i = 1'b1;
      #1;
      check({tag, "_cmd_yumi"}, 64'(cmd_resp_yumi_o), 64'(exp_src == e_resp_src_cmd));
      check({tag, "_req_yumi"}, 64'(req_resp_yumi_o), 64'(exp_src == e_resp_src_req));
      held = (exp_src == e_resp_src_req) ? req_resp_i : cmd_resp_i;
      tick();
      check({tag, "_v"},    64'(lce_resp_v_o), 64'd1);
      check({tag, "_data"}, 64'(lce_resp_o),   64'(held));
      check({tag, "_last"}, 64'(last_grant_o), 64'(exp_src));
      if (exp_src == e_resp_src_req) req_cnt++;
      else                           cmd_cnt++;
   endtask

   initial begin
      logic [W-1:0] m;
      reset_i         = 1'b1;
      sync_mode_i     = 1'b0;
      cmd_resp_i      = '0;
      cmd_resp_v_i    = 1'b0;
      req_resp_i      = '0;
      req_resp_v_i    = 1'b0;
      lce_resp_yumi_i = 1'b0;

      // Reset and idle
      repeat (3) tick();
      check("rst_v",    64'(lce_resp_v_o),    64'd0);
      check("rst_cyum", 64'(cmd_resp_yumi_o), 64'd0);
      check("rst_ryum", 64'(req_resp_yumi_o), 64'd0);
      check("rst_data", 64'(lce_resp_o),      64'd0);
      check("rst_last", 64'(last_grant_o),    64'd1);
      reset_i = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("idle_v",    64'(lce_resp_v_o),                      64'd0);
         check("idle_yumi", 64'({cmd_resp_yumi_o, req_resp_yumi_o}), 64'd0);
         check("idle_data", 64'(lce_resp_o),                        64'd0);
      end

      // Single request
      m            = mk(e_lce_cce_tr_ack, 22'h1040, 1'b1);
      req_resp_i   = m;
      req_resp_v_i = 1'b1;
      #1;
      check("single_ryum", 64'(req_resp_yumi_o), 64'd1);
      check("single_cyum", 64'(cmd_resp_yumi_o), 64'd0);
      tick();
      req_resp_v_i = 1'b0;
      check("single_v",    64'(lce_resp_v_o),     64'd1);
      check("single_addr", 64'(lce_resp_o[AW-1:0]), 64'h1040);
      check("single_data", 64'(lce_resp_o),       64'(m));
      check("single_last", 64'(last_grant_o),     64'd1);
      lce_resp_yumi_i = 1'b1;
      #1;
      check("drain_yumi", 64'({cmd_resp_yumi_o, req_resp_yumi_o}), 64'd0);
      tick();
      check("drain_v", 64'(lce_resp_v_o), 64'd0);

      // Round-robin contention, one message per cycle
      for (int i = 0; i < 4; i++)
         contest("rr", (i % 2 == 1) ? e_resp_src_req : e_resp_src_cmd);

      // Sync override: cmd wins regardless of pointer, then round-robin resumes
      sync_mode_i = 1'b1;
      for (int i = 0; i < 3; i++) contest("sync", e_resp_src_cmd);
      sync_mode_i = 1'b0;
      contest("post_sync", e_resp_src_req);

      // Backpressure: full with req message, sink stalled, sync toggled
      lce_resp_yumi_i = 1'b0;
      cmd_resp_i      = mk(e_lce_cce_inv_ack, AW'(22'h100 + cmd_cnt), 1'b0);
      req_resp_i      = mk(e_lce_cce_coh_ack, AW'(22'h200 + req_cnt), 1'b1);
      for (int i = 0; i < 5; i++) begin
         sync_mode_i = (i % 2 == 0);
         #1;
         check("bp_yumi", 64'({cmd_resp_yumi_o, req_resp_yumi_o}), 64'd0);
         tick();
         check("bp_v",    64'(lce_resp_v_o), 64'd1);
         check("bp_data", 64'(lce_resp_o),   64'(held));
         check("bp_last", 64'(last_grant_o), 64'd1);
      end
      sync_mode_i = 1'b0;
      contest("bp_refill", e_resp_src_cmd);

      // Reset mid-transfer while full and stalled
      lce_resp_yumi_i = 1'b0;
      reset_i         = 1'b1;
      #1;
      check("mrst_yumi", 64'({cmd_resp_yumi_o, req_resp_yumi_o}), 64'd0);
      tick();
      check("mrst_v",    64'(lce_resp_v_o), 64'd0);
      check("mrst_data", 64'(lce_resp_o),   64'd0);
      check("mrst_last", 64'(last_grant_o), 64'd1);
      reset_i = 1'b0;
      contest("post_rst", e_resp_src_cmd);

      // Drain to empty with no valids
      cmd_resp_v_i = 1'b0;
      req_resp_v_i = 1'b0;
      lce_resp_yumi_i = 1'b1;
      tick();
      check("final_v", 64'(lce_resp_v_o), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
